// File: rtl/blue_show_pkg.sv
// Shared constants for the blue player sprite renderer: sprite geometry, the
// transparent colour, frame-select codes and blue_state bit positions.
package blue_show_pkg;

  localparam int SPRITE_W = 47;
  localparam int SPRITE_H = 41;
  localparam logic [13:0] SPRITE_PIXELS = 14'd1927;

  localparam logic [11:0] TRANSPARENT = 12'h428;

  localparam logic [1:0] FRAME_STAND = 2'b00;
  localparam logic [1:0] FRAME_WALK0 = 2'b01;
  localparam logic [1:0] FRAME_WALK1 = 2'b10;
  localparam logic [1:0] FRAME_JUMP  = 2'b11;

  localparam int ST_MOVE  = 0;
  localparam int ST_AIR   = 1;
  localparam int ST_RIGHT = 2;

  localparam int ROM_AW    = 14;
  localparam int ROM_DEPTH = 1 << ROM_AW;

endpackage

// File: rtl/blue_show_sprite_if.sv
// Pixel-request bus between the address generator (master) and the sprite
// renderer (slave).
interface blue_show_sprite_if;
  // No valid/ready: the master presents one pixel request every cycle and
  // vga_blue returns the matching pixel exactly two rising edges later.
  logic [31:0] ipcnt;
  logic [13:0] blue;
  logic [2:0]  blue_state;
  logic [11:0] vga_blue;

  modport master (output ipcnt, output blue, output blue_state, input vga_blue);
  modport slave  (input ipcnt, input blue, input blue_state, output vga_blue);
endinterface

// File: rtl/blue_sprite_rom.sv
// 16384 x 12 synchronous read-only frame memory (8 frames x 2048 words).
// Contents are loaded by other means; INIT_FILE names the intended image.
module blue_sprite_rom
  import blue_show_pkg::*;
#(
  parameter string INIT_FILE = "blue.mem"
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [11:0]       data_o
);

  logic [11:0] rom_mem [ROM_DEPTH];
  logic [11:0] data_q;

  always_ff @(posedge clk) begin
    data_q <= rom_mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/blue_show_sprite.sv
// Blue player sprite renderer: frame select + range check, then a 2-stage
// pipeline through the frame ROM. Optional macro: BLUE_SHOW_AIR_FRAME_EN.
module blue_show_sprite
  import blue_show_pkg::*;
#(
  parameter logic [31:0] ANIM_HALF = 32'd3_000_000,
  parameter string       INIT_FILE = "blue.mem"
) (
  input logic               clk,
  input logic               reset,
  blue_show_sprite_if.slave bus
);

  logic [1:0]        sel_d;
  logic [ROM_AW-1:0] addr_d, addr_q;
  logic              oor_d, oor_q;
  logic              oor_dly_q;
  logic [11:0]       rom_data;

  always_comb begin
    sel_d = FRAME_STAND;
    if (bus.blue_state[ST_AIR]) begin
`ifdef BLUE_SHOW_AIR_FRAME_EN
      sel_d = FRAME_JUMP;
`else
      sel_d = FRAME_STAND;
`endif
    end else if (bus.blue_state[ST_MOVE]) begin
      sel_d = (bus.ipcnt < ANIM_HALF) ? FRAME_WALK0 : FRAME_WALK1;
    end
  end

  assign addr_d = {bus.blue_state[ST_RIGHT], sel_d, bus.blue[10:0]};
  assign oor_d  = (bus.blue >= SPRITE_PIXELS);

  // The range flag travels alongside the ROM read so it masks the same pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      oor_q     <= 1'b1;
      oor_dly_q <= 1'b1;
    end else begin
      addr_q    <= addr_d;
      oor_q     <= oor_d;
      oor_dly_q <= oor_q;
    end
  end

  blue_sprite_rom #(
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  assign bus.vga_blue = oor_dly_q ? TRANSPARENT : rom_data;

endmodule

// File: tb/tb_blue_show_sprite.sv
// Bench for blue_show_sprite: preloads a known ROM image, then checks a
// vector table, a full back-to-back stream, a mid-stream reset and random pixels.
module tb_blue_show_sprite;
  import blue_show_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blue_show_sprite_if bus_if ();

  blue_show_sprite #(
    .ANIM_HALF (32'd3_000_000),
    .INIT_FILE ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  st;
    logic [13:0] b;
    logic [31:0] ip;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs[$];

  // Known, never-transparent image; frames differ at every word.
  function automatic logic [11:0] pat(input int a);
    logic [11:0] v;
    v = 12'((a * 7) + ((a >> 11) * 1234) + 3);
    if (v == 12'h428) v = 12'h429;
    return v;
  endfunction

  function automatic logic [11:0] model(input logic [2:0] st, input logic [13:0] b,
                                        input logic [31:0] ip);
    logic [1:0] s;
    if (b > 14'd1926) return 12'h428;
    if (st[1]) begin
`ifdef BLUE_SHOW_AIR_FRAME_EN
      s = 2'b11;
`else
      s = 2'b00;
`endif
    end else if (st[0] && ip >= 32'd3_000_000) s = 2'b10;
    else if (st[0]) s = 2'b01;
    else s = 2'b00;
    return pat(int'({st[2], s, b[10:0]}));
  endfunction

  // Compare the pixel due this cycle, then drive the next request.
  task automatic step(input logic rst, input logic [2:0] st, input logic [13:0] b,
                      input logic [31:0] ip, input logic [11:0] exp, input string nm);
    logic [11:0] got, e;
    string n;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      got = bus_if.vga_blue;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: vga_blue got %h expected %h", n, got, e);
      end
    end
    reset = rst;
    bus_if.blue_state = st;
    bus_if.blue = b;
    bus_if.ipcnt = ip;
    if (rst) begin
      foreach (exp_q[i]) exp_q[i] = 12'h428;
      exp_q.push_back(12'h428);
    end else begin
      exp_q.push_back(exp);
    end
    name_q.push_back(nm);
  endtask

  task automatic step_m(input logic [2:0] st, input logic [13:0] b, input logic [31:0] ip,
                        input string nm);
    step(1'b0, st, b, ip, model(st, b, ip), nm);
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) dut.u_rom.rom_mem[i] = pat(i);
    reset = 1'b1;
    bus_if.blue_state = 3'b000;
    bus_if.blue = '0;
    bus_if.ipcnt = '0;

    vecs.push_back('{1'b1, 3'b111, 14'd77, 32'd5, 12'h428, "reset0"});
    vecs.push_back('{1'b1, 3'b010, 14'd300, 32'd9, 12'h428, "reset1"});
    vecs.push_back('{1'b1, 3'b101, 14'd0, 32'd4_000_000, 12'h428, "reset2"});
    vecs.push_back('{1'b0, 3'b100, 14'd0, 32'd0, pat({3'b100, 11'd0}), "post_reset_word0"});
    vecs.push_back('{1'b0, 3'b100, 14'd5, 32'd0, pat({3'b100, 11'd5}), "stand_right"});
    vecs.push_back('{1'b0, 3'b000, 14'd5, 32'd0, pat({3'b000, 11'd5}), "stand_left"});
    vecs.push_back('{1'b0, 3'b101, 14'd100, 32'd2_999_999, pat({3'b101, 11'd100}), "walk0_edge"});
    vecs.push_back('{1'b0, 3'b101, 14'd100, 32'd3_000_000, pat({3'b110, 11'd100}), "walk1_edge"});
    vecs.push_back('{1'b0, 3'b001, 14'd100, 32'd0, pat({3'b001, 11'd100}), "walk0_left"});
    vecs.push_back('{1'b0, 3'b001, 14'd100, 32'd6_000_000, pat({3'b010, 11'd100}), "walk_over_max"});
    vecs.push_back('{1'b0, 3'b101, 14'd7, 32'hFFFF_FFFF, pat({3'b110, 11'd7}), "walk_all_ones"});
`ifdef BLUE_SHOW_AIR_FRAME_EN
    vecs.push_back('{1'b0, 3'b011, 14'd1926, 32'd0, pat({3'b011, 11'd1926}), "air_left"});
    vecs.push_back('{1'b0, 3'b110, 14'd1926, 32'd0, pat({3'b111, 11'd1926}), "air_right"});
`else
    vecs.push_back('{1'b0, 3'b011, 14'd1926, 32'd0, pat({3'b000, 11'd1926}), "air_left"});
    vecs.push_back('{1'b0, 3'b110, 14'd1926, 32'd0, pat({3'b100, 11'd1926}), "air_right"});
`endif
    vecs.push_back('{1'b0, 3'b100, 14'd1927, 32'd0, 12'h428, "range_1927"});
    vecs.push_back('{1'b0, 3'b000, 14'd16383, 32'd0, 12'h428, "range_16383"});
    vecs.push_back('{1'b0, 3'b101, 14'd2048, 32'd0, 12'h428, "range_2048"});
    vecs.push_back('{1'b0, 3'b000, 14'd1926, 32'd0, pat({3'b000, 11'd1926}), "last_pixel"});

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].st, vecs[i].b, vecs[i].ip, vecs[i].exp, vecs[i].nm);

    // Back-to-back stream with a state flip at pixel 1000.
    for (int b = 0; b < 1927; b++)
      step_m((b < 1000) ? 3'b101 : 3'b100, 14'(b), 32'd100, "stream");

    // Reset mid-stream drops the two pixels in flight.
    for (int b = 0; b < 6; b++) step_m(3'b001, 14'(b), 32'd3_500_000, "pre_reset");
    step(1'b1, 3'b001, 14'd6, 32'd0, 12'h428, "mid_reset");
    for (int b = 7; b < 12; b++) step_m(3'b001, 14'(b), 32'd3_500_000, "post_reset");

    for (int i = 0; i < 400; i++)
      step_m(3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? 14'($urandom_range(1927, 16383))
                                         : 14'($urandom_range(0, 1926)),
             32'($urandom_range(0, 6_500_000)), "random");

    step_m(3'b000, 14'd0, 32'd0, "drain");
    step_m(3'b000, 14'd0, 32'd0, "drain");
    step_m(3'b000, 14'd0, 32'd0, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
